// File: rtl/evr_trigger_pkg.sv
// Shared definitions for the EVR event-to-trigger mapper: configuration op
// codes, FSM state encoding and the null event code.
// No ports (package).
package evr_trigger_pkg;

  localparam int unsigned TABLE_DEPTH = 256;
  localparam int unsigned CFG_WIDTH   = 32;
  localparam logic [7:0]  NULL_EVENT  = 8'd0;

  typedef enum logic [1:0] {
    OP_TABLE_WRITE = 2'd0,
    OP_SET_HOLDOFF = 2'd1,
    OP_CLEAR_TABLE = 2'd2,
    OP_FORCE       = 2'd3
  } op_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  // Op field lives in the top two bits of every configuration word.
  function automatic op_e cfg_op(input logic [CFG_WIDTH-1:0] data);
    return op_e'(data[CFG_WIDTH-1:CFG_WIDTH-2]);
  endfunction

endpackage

// File: rtl/trigger_holdoff.sv
// Per-output retrigger holdoff.
// Ports: clk, rst (sync, active-high), candidate (wants to fire this cycle),
//        holdoff_value (reload value), fire_c (combinational: candidate accepted).
// A candidate is accepted only while the counter is zero; acceptance reloads
// the counter, which then counts down by one per cycle. Rejected candidates
// are dropped.
module trigger_holdoff #(
  parameter int unsigned HOLDOFF_WIDTH = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     candidate,
  input  logic [HOLDOFF_WIDTH-1:0] holdoff_value,
  output logic                     fire_c
);

  logic [HOLDOFF_WIDTH-1:0] count;

  assign fire_c = candidate && (count == '0);

  // Reload on fire, otherwise count down towards zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (fire_c) begin
      count <= holdoff_value;
    end else if (count != '0) begin
      count <= count - HOLDOFF_WIDTH'(1);
    end
  end

endmodule

// File: rtl/event_trigger_mapper.sv
// Maps the received EVR event-code stream to per-output trigger strobes via a
// 256-entry mask table, with per-output holdoff.
// Ports: evrClk, evrRst (sync, active-high), eventCode/eventStrobe (event in),
//        cfgStrobe/cfgData (configuration word), cfgBusy (table clear running),
//        triggerStrobe (one-cycle pulse per output),
//        cntSelect/cntValue (only with TRIGGER_COUNTERS_EN: per-output pulse counters).
// Optional feature macro: TRIGGER_COUNTERS_EN.
// Event-to-strobe latency is two cycles: table read register, then strobe register.
module event_trigger_mapper
  import evr_trigger_pkg::*;
#(
  parameter int unsigned NUM_OUTPUTS   = 8,
  parameter int unsigned HOLDOFF_WIDTH = 20,
  parameter string       DEBUG         = "false"
) (
  input  logic                   evrClk,
  input  logic                   evrRst,
  input  logic [7:0]             eventCode,
  input  logic                   eventStrobe,
  input  logic                   cfgStrobe,
  input  logic [CFG_WIDTH-1:0]   cfgData,
  output logic                   cfgBusy,
  output logic [NUM_OUTPUTS-1:0] triggerStrobe
`ifdef TRIGGER_COUNTERS_EN
  ,
  input  logic [3:0]             cntSelect,
  output logic [31:0]            cntValue
`endif
);

  state_e state, state_d;
  logic [7:0] clr_addr, clr_addr_d;

  logic                   wr_en;
  logic [7:0]             wr_addr;
  logic [NUM_OUTPUTS-1:0] wr_data;

  logic [NUM_OUTPUTS-1:0] mem [TABLE_DEPTH];
  logic [NUM_OUTPUTS-1:0] rd_q;
  logic                   ev_valid_q;
  logic [NUM_OUTPUTS-1:0] force_q;
  logic [NUM_OUTPUTS-1:0] cand;
  logic [NUM_OUTPUTS-1:0] fire;
  logic [HOLDOFF_WIDTH-1:0] hold_val [NUM_OUTPUTS];

  op_e  op;
  logic lookup_c;
  logic unused_cfg;

  assign op         = cfg_op(cfgData);
  assign lookup_c   = eventStrobe && (eventCode != NULL_EVENT) && (state == S_IDLE);
  assign unused_cfg = ^cfgData[29:28];

  // FSM state register; cfgBusy tracks the clear state exactly.
  always_ff @(posedge evrClk) begin
    if (evrRst) begin
      state    <= S_IDLE;
      clr_addr <= '0;
      cfgBusy  <= 1'b0;
    end else begin
      state    <= state_d;
      clr_addr <= clr_addr_d;
      cfgBusy  <= (state_d == S_CLEAR);
    end
  end

  // Next state and table write port: config writes in idle, zero sweep in clear.
  always_comb begin
    state_d    = state;
    clr_addr_d = clr_addr;
    wr_en      = 1'b0;
    wr_addr    = cfgData[23:16];
    wr_data    = cfgData[NUM_OUTPUTS-1:0];
    case (state)
      S_IDLE: begin
        if (cfgStrobe && (op == OP_TABLE_WRITE)) begin
          wr_en = !evrRst;
        end else if (cfgStrobe && (op == OP_CLEAR_TABLE)) begin
          state_d    = S_CLEAR;
          clr_addr_d = '0;
        end
      end
      S_CLEAR: begin
        wr_en      = !evrRst;
        wr_addr    = clr_addr;
        wr_data    = '0;
        clr_addr_d = clr_addr + 8'd1;
        if (clr_addr == 8'hFF) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Simple-dual-port table; a same-address write and read yields the old mask.
  always_ff @(posedge evrClk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_q <= mem[eventCode];
  end

  // Lookup qualifier and FORCE mask, both aligned with the table read.
  always_ff @(posedge evrClk) begin
    if (evrRst) begin
      ev_valid_q <= 1'b0;
      force_q    <= '0;
    end else begin
      ev_valid_q <= lookup_c;
      force_q    <= (cfgStrobe && (op == OP_FORCE)) ? cfgData[NUM_OUTPUTS-1:0] : '0;
    end
  end

  // Holdoff reload values; indices beyond the output count are ignored.
  always_ff @(posedge evrClk) begin
    if (evrRst) begin
      for (int i = 0; i < int'(NUM_OUTPUTS); i++) begin
        hold_val[i] <= '0;
      end
    end else if (cfgStrobe && (op == OP_SET_HOLDOFF)) begin
      for (int i = 0; i < int'(NUM_OUTPUTS); i++) begin
        if (cfgData[27:24] == 4'(i)) begin
          hold_val[i] <= cfgData[HOLDOFF_WIDTH-1:0];
        end
      end
    end
  end

  assign cand = (ev_valid_q ? rd_q : '0) | force_q;

  for (genvar g = 0; g < int'(NUM_OUTPUTS); g++) begin : g_holdoff
    trigger_holdoff #(
      .HOLDOFF_WIDTH(HOLDOFF_WIDTH)
    ) u_holdoff (
      .clk          (evrClk),
      .rst          (evrRst),
      .candidate    (cand[g]),
      .holdoff_value(hold_val[g]),
      .fire_c       (fire[g])
    );
  end

  // Strobe output register, tagged for on-chip debug when requested.
  if (DEBUG == "true") begin : g_dbg
    (* mark_debug = "true" *) logic [NUM_OUTPUTS-1:0] strobe_q;
    always_ff @(posedge evrClk) begin
      if (evrRst) strobe_q <= '0;
      else        strobe_q <= fire;
    end
    assign triggerStrobe = strobe_q;
  end else begin : g_nodbg
    logic [NUM_OUTPUTS-1:0] strobe_q;
    always_ff @(posedge evrClk) begin
      if (evrRst) strobe_q <= '0;
      else        strobe_q <= fire;
    end
    assign triggerStrobe = strobe_q;
  end

`ifdef TRIGGER_COUNTERS_EN
  logic [31:0] cnt [NUM_OUTPUTS];

  // Emitted-pulse counters (wrapping) and registered readback mux.
  always_ff @(posedge evrClk) begin
    if (evrRst) begin
      for (int i = 0; i < int'(NUM_OUTPUTS); i++) begin
        cnt[i] <= '0;
      end
      cntValue <= '0;
    end else begin
      cntValue <= '0;
      for (int i = 0; i < int'(NUM_OUTPUTS); i++) begin
        if (fire[i]) begin
          cnt[i] <= cnt[i] + 32'd1;
        end
        if (cntSelect == 4'(i)) begin
          cntValue <= cnt[i];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_event_trigger_mapper.sv
// Self-checking bench for event_trigger_mapper: directed scenarios followed by
// randomized traffic, all checked cycle by cycle against a reference model.
module tb_event_trigger_mapper;

  localparam int NOUT = 8;

  logic        evrClk = 1'b0;
  logic        evrRst = 1'b1;
  logic [7:0]  eventCode = 8'd0;
  logic        eventStrobe = 1'b0;
  logic        cfgStrobe = 1'b0;
  logic [31:0] cfgData = 32'd0;
  logic        cfgBusy;
  logic [7:0]  triggerStrobe;
  logic [3:0]  cntSelect = 4'd0;
  logic [31:0] cntValue;

  always #5 evrClk = ~evrClk;

  event_trigger_mapper #(
    .NUM_OUTPUTS  (NOUT),
    .HOLDOFF_WIDTH(20),
    .DEBUG        ("false")
  ) dut (
    .evrClk       (evrClk),
    .evrRst       (evrRst),
    .eventCode    (eventCode),
    .eventStrobe  (eventStrobe),
    .cfgStrobe    (cfgStrobe),
    .cfgData      (cfgData),
    .cfgBusy      (cfgBusy),
    .triggerStrobe(triggerStrobe)
`ifdef TRIGGER_COUNTERS_EN
    ,
    .cntSelect    (cntSelect),
    .cntValue     (cntValue)
`endif
  );

`ifndef TRIGGER_COUNTERS_EN
  assign cntValue = 32'd0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: mask table, holdoff settings, earliest cycle each output
  // may fire again, remaining clear cycles, pulse counts.
  logic [7:0]  tbl_m [256];
  int          hold_m [NOUT];
  int          next_ok [NOUT];
  logic [31:0] cnt_m [NOUT];
  int          rem = 0;
  logic [7:0]  cand_cur = 8'd0;
  int          t = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, t);
    end
  endtask

  function automatic logic [31:0] w_write(input logic [7:0] a, input logic [7:0] m);
    return {2'd0, 6'd0, a, 8'd0, m};
  endfunction
  function automatic logic [31:0] w_hold(input logic [3:0] idx, input logic [19:0] v);
    return {2'd1, 2'd0, idx, 4'd0, v};
  endfunction
  function automatic logic [31:0] w_clear();
    return {2'd2, 30'd0};
  endfunction
  function automatic logic [31:0] w_force(input logic [7:0] m);
    return {2'd3, 22'd0, m};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NOUT; i++) begin
      hold_m[i]  = 0;
      next_ok[i] = 0;
      cnt_m[i]   = 32'd0;
    end
    rem      = 0;
    cand_cur = 8'd0;
  endtask

  task automatic do_reset();
    evrRst = 1'b1;
    eventStrobe = 1'b0; cfgStrobe = 1'b0; eventCode = 8'd0; cfgData = 32'd0;
    repeat (2) @(posedge evrClk);
    #1;
    model_reset();
    check("rst_strobe", 32'(triggerStrobe), 32'd0);
    check("rst_busy", 32'(cfgBusy), 32'd0);
`ifdef TRIGGER_COUNTERS_EN
    check("rst_cnt", cntValue, 32'd0);
`endif
    evrRst = 1'b0;
  endtask

  // One clock of stimulus; outputs of the following cycle are checked.
  task automatic step(input logic es, input logic [7:0] code, input logic cs, input logic [31:0] data);
    logic [7:0]  exp_s;
    logic [7:0]  lk;
    logic [7:0]  fm;
    logic [31:0] exp_cnt;
    int          rem_next;
    eventStrobe = es; eventCode = code; cfgStrobe = cs; cfgData = data;
    exp_s   = 8'd0;
    exp_cnt = (cntSelect < 4'd8) ? cnt_m[3'(cntSelect)] : 32'd0;
    for (int i = 0; i < NOUT; i++) begin
      if (cand_cur[i] && t >= next_ok[i]) begin
        exp_s[i]   = 1'b1;
        next_ok[i] = t + 1 + hold_m[i];
        cnt_m[i]   = cnt_m[i] + 32'd1;
      end
    end
    lk = (es && code != 8'd0 && rem == 0) ? tbl_m[code] : 8'd0;
    fm = (cs && data[31:30] == 2'd3) ? data[7:0] : 8'd0;
    rem_next = (rem > 0) ? rem - 1 : 0;
    if (cs) begin
      case (data[31:30])
        2'd0: if (rem == 0) tbl_m[data[23:16]] = data[7:0];
        2'd1: if (data[27:24] < 4'd8) hold_m[3'(data[27:24])] = int'(data[19:0]);
        2'd2: if (rem == 0) begin
                for (int a = 0; a < 256; a++) tbl_m[a] = 8'd0;
                rem_next = 256;
              end
        default: ;
      endcase
    end
    @(posedge evrClk);
    #1;
    rem      = rem_next;
    cand_cur = lk | fm;
    t++;
    check("strobe", 32'(triggerStrobe), 32'(exp_s));
    check("busy", 32'(cfgBusy), 32'(rem != 0));
`ifdef TRIGGER_COUNTERS_EN
    check("cnt", cntValue, exp_cnt);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, 1'b0, 32'd0);
  endtask

  initial begin
    int busy_n;
    logic [31:0] pulses;
    model_reset();
    for (int a = 0; a < 256; a++) tbl_m[a] = 8'd0;
    do_reset();

    // Initial clear; cfgBusy must stay high for exactly 256 cycles.
    step(1'b0, 8'd0, 1'b1, w_clear());
    busy_n = int'(cfgBusy);
    for (int k = 0; k < 257; k++) begin
      idle(1);
      busy_n += int'(cfgBusy);
    end
    check("clr_len", 32'(busy_n), 32'd256);

    // Basic lookup, two-cycle latency.
    step(1'b0, 8'd0, 1'b1, w_write(8'h2A, 8'h05));
    step(1'b1, 8'h2A, 1'b0, 32'd0);
    check("t1_n1", 32'(triggerStrobe), 32'd0);
    idle(1);
    check("t1_n2", 32'(triggerStrobe), 32'h05);
    idle(1);
    check("t1_n3", 32'(triggerStrobe), 32'd0);

    // Null event never fires.
    step(1'b0, 8'd0, 1'b1, w_write(8'h00, 8'hFF));
    step(1'b1, 8'h00, 1'b0, 32'd0);
    idle(1);
    check("t2_null", 32'(triggerStrobe), 32'd0);
    idle(2);

    // Holdoff 10 on output 0: events at 0, 5, 12 -> pulses at 2 and 14.
    step(1'b0, 8'd0, 1'b1, w_hold(4'd0, 20'd10));
    step(1'b0, 8'd0, 1'b1, w_write(8'h10, 8'h01));
    pulses = 32'd0;
    for (int k = 0; k < 18; k++) begin
      step((k == 0 || k == 5 || k == 12), 8'h10, 1'b0, 32'd0);
      if (triggerStrobe[0]) pulses = pulses | (32'd1 << (k + 1));
    end
    check("t3_holdoff", pulses, (32'd1 << 2) | (32'd1 << 14));
    step(1'b0, 8'd0, 1'b1, w_hold(4'd0, 20'd0));

    // Clear: lookups suppressed, FORCE honoured, table empty afterwards.
    step(1'b0, 8'd0, 1'b1, w_clear());
    busy_n = int'(cfgBusy);
    for (int k = 1; k <= 256; k++) begin
      step(k == 3, 8'h2A, k == 10, w_force(8'h80));
      busy_n += int'(cfgBusy);
      if (k == 4)  check("t4_ev_in_clear", 32'(triggerStrobe), 32'd0);
      if (k == 11) check("t4_force", 32'(triggerStrobe), 32'h80);
    end
    check("t4_busy_len", 32'(busy_n), 32'd256);
    step(1'b1, 8'h2A, 1'b0, 32'd0);
    idle(1);
    check("t4_after", 32'(triggerStrobe), 32'd0);

    // FORCE ORed with event mask; same-cycle write returns the old mask.
    step(1'b0, 8'd0, 1'b1, w_write(8'h2A, 8'h05));
    step(1'b1, 8'h2A, 1'b1, w_force(8'h02));
    idle(1);
    check("t5_or", 32'(triggerStrobe), 32'h07);
    step(1'b1, 8'h2A, 1'b1, w_write(8'h2A, 8'h40));
    idle(1);
    check("t5_old", 32'(triggerStrobe), 32'h05);
    step(1'b1, 8'h2A, 1'b0, 32'd0);
    idle(1);
    check("t5_new", 32'(triggerStrobe), 32'h40);

    // SET_HOLDOFF with index beyond the output count has no effect.
    step(1'b0, 8'd0, 1'b1, w_hold(4'd9, 20'd50));

`ifdef TRIGGER_COUNTERS_EN
    do_reset();
    cntSelect = 4'd2;
    step(1'b0, 8'd0, 1'b1, w_write(8'h33, 8'h04));
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 8'h33, 1'b0, 32'd0);
      idle(1);
    end
    idle(2);
    check("t6_cnt3", cntValue, 32'd3);
    cntSelect = 4'd12;
    idle(1);
    check("t6_sel_oob", cntValue, 32'd0);
    cntSelect = 4'd2;
    do_reset();
`endif

    // Reset in the middle of a clear aborts it; then re-clear.
    step(1'b0, 8'd0, 1'b1, w_clear());
    idle(10);
    do_reset();
    step(1'b0, 8'd0, 1'b1, w_clear());
    idle(257);

    // Randomized traffic.
    for (int k = 0; k < 2500; k++) begin
      logic        es;
      logic [7:0]  code;
      logic        cs;
      logic [31:0] data;
      int          r;
      es   = 1'($urandom_range(0, 1));
      code = 8'($urandom_range(0, 15));
      r    = int'($urandom_range(0, 199));
      cs   = 1'b1;
      if (r < 50)       data = w_write(8'($urandom_range(0, 15)), 8'($urandom)) | {8'd0, 8'd0, 8'($urandom), 8'd0};
      else if (r < 75)  data = w_hold(4'($urandom_range(0, 15)), 20'($urandom_range(0, 7))) | {8'd0, 4'($urandom), 20'd0};
      else if (r < 100) data = w_force(8'($urandom));
      else if (r == 100) data = w_clear();
      else begin
        cs = 1'b0; data = $urandom;
      end
      cntSelect = 4'($urandom_range(0, 15));
      step(es, code, cs, data);
    end
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
